// File: rtl/perf_counter_pkg.sv
// Shared register map, CTRL bit positions and legal parameter bounds for perf_counter_bank.
package perf_counter_pkg;

  localparam int unsigned ADDR_W = 6;

  localparam logic [ADDR_W-1:0] REG_CTRL       = 6'h00;
  localparam logic [ADDR_W-1:0] REG_CLEAR      = 6'h01;
  localparam logic [ADDR_W-1:0] REG_OVF        = 6'h02;
  localparam logic [ADDR_W-1:0] REG_SEL_BASE   = 6'h04;
  localparam logic [ADDR_W-1:0] REG_COUNT_BASE = 6'h10;

  localparam int unsigned CTRL_EN    = 0;
  localparam int unsigned CTRL_SNAP  = 1;
  localparam int unsigned CTRL_RDSHD = 2;

  localparam int unsigned MIN_NUM_CNT    = 2;
  localparam int unsigned MAX_NUM_CNT    = 12;
  localparam int unsigned MIN_CNT_WIDTH  = 8;
  localparam int unsigned MAX_CNT_WIDTH  = 32;
  localparam int unsigned MIN_NUM_EVENTS = 2;
  localparam int unsigned MAX_NUM_EVENTS = 32;

endpackage

// File: rtl/perf_counter_cell.sv
// One performance counter: count, event select, sticky overflow and optional shadow.
// Shadow register present only when PERFCNT_SNAPSHOT_EN is defined.
module perf_counter_cell #(
  parameter int unsigned IDX        = 0,
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned NUM_EVENTS = 8,
  parameter int unsigned SEL_W      = 3
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic [NUM_EVENTS-1:0] event_vec,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  load,
  input  logic [CNT_WIDTH-1:0]  load_data,
  input  logic                  sel_we,
  input  logic [SEL_W-1:0]      sel_data,
  input  logic                  snap,
  input  logic                  ovf_clr,
  output logic [CNT_WIDTH-1:0]  count,
  output logic [SEL_W-1:0]      sel,
  output logic                  ovf,
  output logic [CNT_WIDTH-1:0]  shadow
);

  localparam logic [SEL_W-1:0] SEL_RST = SEL_W'(IDX % NUM_EVENTS);

  logic inc;
  logic wrap;

  // Cell 0 is the cycle counter and ignores its (constant-zero) select.
  assign inc  = en & ((IDX == 0) | event_vec[sel]);
  assign wrap = inc & (count == '1);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_data;
    end else if (inc) begin
      count <= count + CNT_WIDTH'(1);
    end
  end

  // A fresh wrap outranks a same-cycle write-1-to-clear.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (clr) begin
      ovf <= 1'b0;
    end else if (wrap && !load) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      sel <= SEL_RST;
    end else if (sel_we) begin
      sel <= sel_data;
    end
  end

`ifdef PERFCNT_SNAPSHOT_EN
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      shadow <= '0;
    end else if (snap) begin
      shadow <= count;
    end
  end
`else
  logic unused_snap;
  assign unused_snap = snap;
  assign shadow      = '0;
`endif

endmodule

// File: rtl/perf_counter_bank.sv
// Memory-mapped bank of performance counters with sticky overflow flags and interrupt.
// Optional atomic snapshot/shadow readback enabled by defining PERFCNT_SNAPSHOT_EN.
module perf_counter_bank
  import perf_counter_pkg::*;
#(
  parameter int unsigned NUM_CNT    = 4,
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned NUM_EVENTS = 8,
  parameter int unsigned SEL_W      = $clog2(NUM_EVENTS)
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic [NUM_EVENTS-1:0] event_vec,
  input  logic [5:0]            addr,
  input  logic                  wr_en,
  input  logic [31:0]           wr_data,
  input  logic                  rd_en,
  output logic [31:0]           rd_data,
  output logic                  ovf_irq
);

  if (NUM_CNT < MIN_NUM_CNT || NUM_CNT > MAX_NUM_CNT ||
      CNT_WIDTH < MIN_CNT_WIDTH || CNT_WIDTH > MAX_CNT_WIDTH ||
      NUM_EVENTS < MIN_NUM_EVENTS || NUM_EVENTS > MAX_NUM_EVENTS ||
      (NUM_EVENTS & (NUM_EVENTS - 1)) != 0) begin : g_param_err
    $error("perf_counter_bank: parameter out of legal range");
  end

  logic                 en_q;
  logic                 rdshd_q;
  logic                 snap;
  logic                 hit_ctrl;
  logic                 hit_clear;
  logic                 hit_ovf;
  logic [NUM_CNT-1:0]   ovf_vec;
  logic [CNT_WIDTH-1:0] count_arr  [NUM_CNT];
  logic [CNT_WIDTH-1:0] shadow_arr [NUM_CNT];
  logic [SEL_W-1:0]     sel_arr    [NUM_CNT];
  logic [31:0]          rd_mux;

  assign hit_ctrl  = (addr == REG_CTRL);
  assign hit_clear = (addr == REG_CLEAR);
  assign hit_ovf   = (addr == REG_OVF);

  // EN is registered, so a write changes counting from the following cycle.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      en_q <= 1'b1;
    end else if (wr_en && hit_ctrl) begin
      en_q <= wr_data[CTRL_EN];
    end
  end

`ifdef PERFCNT_SNAPSHOT_EN
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      rdshd_q <= 1'b0;
    end else if (wr_en && hit_ctrl) begin
      rdshd_q <= wr_data[CTRL_RDSHD];
    end
  end
  assign snap = wr_en & hit_ctrl & wr_data[CTRL_SNAP];
`else
  assign rdshd_q = 1'b0;
  assign snap    = 1'b0;
`endif

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    logic clr_i;
    logic load_i;
    logic sel_we_i;
    logic ovf_clr_i;

    assign clr_i     = wr_en & hit_clear & wr_data[i];
    assign load_i    = wr_en & (addr == REG_COUNT_BASE + 6'(i));
    assign sel_we_i  = wr_en & (i != 0) & (addr == REG_SEL_BASE + 6'(i));
    assign ovf_clr_i = wr_en & hit_ovf & wr_data[i];

    perf_counter_cell #(
      .IDX        (i),
      .CNT_WIDTH  (CNT_WIDTH),
      .NUM_EVENTS (NUM_EVENTS),
      .SEL_W      (SEL_W)
    ) u_cell (
      .CLK       (CLK),
      .reset     (reset),
      .event_vec (event_vec),
      .en        (en_q),
      .clr       (clr_i),
      .load      (load_i),
      .load_data (wr_data[CNT_WIDTH-1:0]),
      .sel_we    (sel_we_i),
      .sel_data  (wr_data[SEL_W-1:0]),
      .snap      (snap),
      .ovf_clr   (ovf_clr_i),
      .count     (count_arr[i]),
      .sel       (sel_arr[i]),
      .ovf       (ovf_vec[i]),
      .shadow    (shadow_arr[i])
    );
  end

  // Mux reads pre-edge state, so a same-cycle write is not visible to the read.
  always_comb begin
    rd_mux = '0;
    if (hit_ctrl) begin
      rd_mux[CTRL_EN]    = en_q;
      rd_mux[CTRL_RDSHD] = rdshd_q;
    end
    if (hit_ovf) begin
      rd_mux[NUM_CNT-1:0] = ovf_vec;
    end
    for (int unsigned i = 0; i < NUM_CNT; i++) begin
      if (addr == REG_SEL_BASE + 6'(i)) begin
        rd_mux[SEL_W-1:0] = sel_arr[i];
      end
      if (addr == REG_COUNT_BASE + 6'(i)) begin
        rd_mux[CNT_WIDTH-1:0] = rdshd_q ? shadow_arr[i] : count_arr[i];
      end
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
      ovf_irq <= 1'b0;
    end else begin
      if (rd_en) begin
        rd_data <= rd_mux;
      end
      ovf_irq <= |ovf_vec;
    end
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Scoreboard bench for perf_counter_bank (CNT_WIDTH=8); expectations follow PERFCNT_SNAPSHOT_EN.
module tb_perf_counter_bank;

  localparam logic [5:0] A_CTRL  = 6'h00;
  localparam logic [5:0] A_CLEAR = 6'h01;
  localparam logic [5:0] A_OVF   = 6'h02;
  localparam logic [5:0] A_UNMAP = 6'h03;
  localparam logic [5:0] A_SEL0  = 6'h04;
  localparam logic [5:0] A_SEL1  = 6'h05;
  localparam logic [5:0] A_SEL2  = 6'h06;
  localparam logic [5:0] A_SEL4  = 6'h08;
  localparam logic [5:0] A_CNT0  = 6'h10;
  localparam logic [5:0] A_CNT1  = 6'h11;
  localparam logic [5:0] A_CNT2  = 6'h12;
  localparam logic [5:0] A_CNT3  = 6'h13;
  localparam logic [5:0] A_CNT4  = 6'h14;

`ifdef PERFCNT_SNAPSHOT_EN
  localparam bit SNAP_ON = 1'b1;
`else
  localparam bit SNAP_ON = 1'b0;
`endif

  logic        CLK;
  logic        reset;
  logic [7:0]  event_vec;
  logic [5:0]  addr;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        ovf_irq;

  int unsigned n_checks;
  int unsigned n_errors;
  string       name_q[$];
  logic [31:0] val_q[$];
  logic        rd_v;

  perf_counter_bank #(
    .NUM_CNT    (4),
    .CNT_WIDTH  (8),
    .NUM_EVENTS (8)
  ) dut (
    .CLK       (CLK),
    .reset     (reset),
    .event_vec (event_vec),
    .addr      (addr),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .ovf_irq   (ovf_irq)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: a read issued in cycle N is presented after edge N+1.
  initial rd_v = 1'b0;
  always @(posedge CLK or posedge reset) begin
    if (reset) rd_v <= 1'b0;
    else       rd_v <= rd_en;
  end

  initial begin
    string       nm;
    logic [31:0] v;
    forever begin
      @(negedge CLK);
      if (rd_v) begin
        if (name_q.size() == 0) begin
          check("unexpected_read", rd_data, 32'hDEAD_BEEF);
        end else begin
          nm = name_q.pop_front();
          v  = val_q.pop_front();
          check(nm, rd_data, v);
        end
      end
    end
  end

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    addr = a; wr_data = d; wr_en = 1'b1;
    @(posedge CLK); #1;
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, input logic [31:0] exp, input string nm);
    addr = a; rd_en = 1'b1;
    name_q.push_back(nm);
    val_q.push_back(exp);
    @(posedge CLK); #1;
    rd_en = 1'b0;
  endtask

  task automatic rw(input logic [5:0] a, input logic [31:0] d, input logic [31:0] exp, input string nm);
    addr = a; wr_data = d; wr_en = 1'b1; rd_en = 1'b1;
    name_q.push_back(nm);
    val_q.push_back(exp);
    @(posedge CLK); #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b1;
    event_vec = '0;
    addr      = '0;
    wr_en     = 1'b0;
    wr_data   = '0;
    rd_en     = 1'b0;

    #12;
    check("reset_rd_data", rd_data, 32'h0);
    check("reset_irq", {31'b0, ovf_irq}, 32'h0);
    @(negedge CLK);
    reset = 1'b0;
    @(posedge CLK); #1;                  // first counting edge: COUNT_0 = 1
    idle(9);                             // COUNT_0 = 10

    rd(A_CNT0,  32'd10, "cnt0_after_reset");
    rd(A_SEL0,  32'd0,  "sel0_reset");
    rd(A_SEL1,  32'd1,  "sel1_reset");
    rd(A_SEL2,  32'd2,  "sel2_reset");
    rd(A_OVF,   32'd0,  "ovf_reset");
    rd(A_CTRL,  32'd1,  "ctrl_reset");
    rd(A_CLEAR, 32'd0,  "clear_reads_0");

    // Event select and counting
    wr(A_SEL2, 32'd3);
    event_vec = 8'h08; idle(5);
    event_vec = 8'h04; idle(4);
    event_vec = 8'h00;
    rd(A_CNT2, 32'd5, "cnt2_sel3");
    rd(A_CNT3, 32'd5, "cnt3_sel3");
    rd(A_CNT1, 32'd0, "cnt1_no_event");
    rd(A_SEL2, 32'd3, "sel2_written");
    idle(3);
    check("rd_hold", rd_data, 32'd3);
    wr(A_SEL0, 32'd5);
    rd(A_SEL0, 32'd0, "sel0_ignores_write");
    wr(A_UNMAP, 32'hFFFF_FFFF);
    rd(A_UNMAP, 32'd0, "unmapped_read");
    rd(A_CNT4,  32'd0, "count_idx_oob");
    rd(A_SEL4,  32'd0, "sel_idx_oob");
    rw(A_CNT2, 32'h55, 32'd5, "read_pre_write");
    rd(A_CNT2, 32'h55, "cnt2_loaded");

    // Overflow and interrupt timing
    wr(A_CLEAR, 32'hF);
    wr(A_CNT1, 32'hFF);
    event_vec = 8'h02; idle(1); event_vec = 8'h00;
    check("irq_lags_flag", {31'b0, ovf_irq}, 32'h0);
    rd(A_OVF, 32'h2, "ovf_set");
    check("irq_set", {31'b0, ovf_irq}, 32'h1);
    rd(A_CNT1, 32'd0, "cnt1_wrapped");
    wr(A_OVF, 32'h2);
    check("irq_hold_after_w1c", {31'b0, ovf_irq}, 32'h1);
    rd(A_OVF, 32'h0, "ovf_w1c");
    check("irq_cleared", {31'b0, ovf_irq}, 32'h0);

    // Overflow beats same-cycle W1C
    wr(A_CNT1, 32'hFF);
    event_vec = 8'h02; wr(A_OVF, 32'h2); event_vec = 8'h00;
    rd(A_OVF, 32'h2, "ovf_beats_w1c");
    wr(A_OVF, 32'h2);
    rd(A_OVF, 32'h0, "ovf_w1c_again");

    // Load beats increment and suppresses overflow
    wr(A_CNT1, 32'hFF);
    event_vec = 8'h02; wr(A_CNT1, 32'h10); event_vec = 8'h00;
    rd(A_CNT1, 32'h10, "load_beats_inc");
    rd(A_OVF,  32'h0,  "load_no_ovf");

    // Clear beats increment and suppresses overflow
    wr(A_CNT1, 32'hFF);
    event_vec = 8'h02; wr(A_CLEAR, 32'h2); event_vec = 8'h00;
    rd(A_CNT1, 32'd0, "clear_beats_inc");
    rd(A_OVF,  32'h0, "clear_no_ovf");
    event_vec = 8'h02; wr(A_CNT1, 32'd7); event_vec = 8'h00;
    rd(A_CNT1, 32'd7, "load7_with_event");
    event_vec = 8'h02; idle(3); event_vec = 8'h00;
    rd(A_CNT1, 32'd10, "cnt1_increments");

    // Global enable
    wr(A_CTRL, 32'h0);
    wr(A_CNT0, 32'h40);
    event_vec = 8'h02; idle(20); event_vec = 8'h00;
    rd(A_CTRL, 32'h0,  "ctrl_en_off");
    rd(A_CNT0, 32'h40, "cnt0_frozen");
    rd(A_CNT1, 32'd10, "cnt1_frozen");
    wr(A_CTRL, 32'h1);
    idle(10);
    rd(A_CNT0, 32'h4A, "cnt0_resumed");

    // Snapshot / shadow readback
    wr(A_CNT0, 32'd100);
    wr(A_CTRL, 32'h3);
    wr(A_CTRL, 32'h5);
    rd(A_CTRL, SNAP_ON ? 32'h5 : 32'h1, "ctrl_rdshd");
    idle(49);
    rd(A_CNT0, SNAP_ON ? 32'd100 : 32'd152, "cnt0_shadow");
    wr(A_CTRL, 32'h1);
    rd(A_CNT0, 32'd154, "cnt0_live");

    // Asynchronous reset mid-operation
    wr(A_CNT1, 32'hFF);
    event_vec = 8'h02; idle(1); event_vec = 8'h00;
    idle(1);
    check("irq_before_reset", {31'b0, ovf_irq}, 32'h1);
    addr = A_OVF; rd_en = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("async_reset_rd_data", rd_data, 32'h0);
    check("async_reset_irq", {31'b0, ovf_irq}, 32'h0);
    @(posedge CLK); #1;
    check("reset_blocks_read", rd_data, 32'h0);
    rd_en = 1'b0;
    @(negedge CLK);
    reset = 1'b0;
    @(posedge CLK); #1;
    rd(A_SEL2, 32'd2, "sel2_after_reset");
    rd(A_OVF,  32'h0, "ovf_after_reset");
    rd(A_CTRL, 32'h1, "ctrl_after_reset");
    rd(A_CNT1, 32'h0, "cnt1_after_reset");

    idle(4);
    check("scoreboard_drained", name_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
